// File: rtl/calc_pkg.sv
// Shared constants and types for the calculator key sequencer:
// key codes, operator encoding, controller states and small decode helpers.
package calc_pkg;

    localparam int CALC_W          = 11;
    localparam int CALC_MAX_DIGITS = 3;
    localparam int CALC_LIMIT      = 999;
    localparam int CALC_TIMEOUT    = 15;
    localparam int RES_W           = 24;

    localparam logic [3:0] KEY_PLUS  = 4'd10;
    localparam logic [3:0] KEY_MINUS = 4'd11;
    localparam logic [3:0] KEY_MULT  = 4'd12;
    localparam logic [3:0] KEY_CLR   = 4'd13;
    localparam logic [3:0] KEY_ENTER = 4'd14;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2
    } op_sel_e;

    typedef enum logic [2:0] {
        ST_SIGN1 = 3'd0,
        ST_DIG1  = 3'd1,
        ST_OP    = 3'd2,
        ST_SIGN2 = 3'd3,
        ST_DIG2  = 3'd4,
        ST_ISSUE = 3'd5,
        ST_WAIT  = 3'd6,
        ST_SHOW  = 3'd7
    } state_e;

    function automatic op_sel_e key_to_op(input logic [3:0] key);
        op_sel_e op;
        case (key)
            KEY_PLUS:  op = OP_ADD;
            KEY_MINUS: op = OP_SUB;
            default:   op = OP_MUL;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/calc_sequencer_if.sv
// Request/response bus between the key sequencer and the shared arithmetic unit.
interface calc_sequencer_if #(
    parameter int W = calc_pkg::CALC_W
);
    import calc_pkg::*;

    logic             op_valid;
    logic             op_ack;
    logic [W-1:0]     op_a;
    logic [W-1:0]     op_b;
    op_sel_e          op_sel;
    logic             res_valid;
    logic [RES_W-1:0] res_data;

    modport master (
        output op_valid, op_a, op_b, op_sel,
        input  op_ack, res_valid, res_data
    );

    modport slave (
        input  op_valid, op_a, op_b, op_sel,
        output op_ack, res_valid, res_data
    );

endinterface

// File: rtl/calc_digit_acc.sv
// Decimal operand accumulator: acc = acc*10 + d per digit, digits beyond
// MAX_DIGITS are dropped so the magnitude never exceeds 10**MAX_DIGITS - 1.
module calc_digit_acc #(
    parameter int W          = 11,
    parameter int MAX_DIGITS = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         push_i,
    input  logic [3:0]   digit_i,
    output logic [W-1:0] acc_o
);

    localparam int CNT_W = $clog2(MAX_DIGITS + 1);

    logic [W-1:0]     acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next accumulator value and digit count
    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (clr_i) begin
            acc_d = {W{1'b0}};
            cnt_d = {CNT_W{1'b0}};
        end else if (push_i && (cnt_q < CNT_W'(MAX_DIGITS))) begin
            acc_d = (acc_q * W'(10)) + W'(digit_i);
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            acc_d = acc_q;
            cnt_d = cnt_q;
        end
    end

    // Accumulator state register
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= {W{1'b0}};
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/calc_sequencer.sv
// Calculator key sequencer: assembles two signed decimal operands and an operator
// from key events, issues one operation to the arithmetic unit and range-checks the result.
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int W          = CALC_W,
    parameter int MAX_DIGITS = CALC_MAX_DIGITS,
    parameter int LIMIT      = CALC_LIMIT,
    parameter int TIMEOUT    = CALC_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_valid_i,
    input  logic [3:0]       key_code_i,
    calc_sequencer_if.master arith,
    output logic [W-1:0]     result_o,
    output logic             result_valid_o,
    output logic             err_o,
    output logic             busy_o
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam logic signed [RES_W-1:0] LIM_P = RES_W'(LIMIT);
    localparam logic signed [RES_W-1:0] LIM_N = RES_W'(-LIMIT);

    state_e           state_q, state_d;
    logic             neg1_q, neg1_d, neg2_q, neg2_d;
    logic [W-1:0]     a_mag_q, a_mag_d;
    op_sel_e          op_sel_q, op_sel_d;
    logic             op_valid_q, op_valid_d;
    logic [W-1:0]     op_a_q, op_a_d, op_b_q, op_b_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [W-1:0]     result_q, result_d;
    logic             result_valid_q, result_valid_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;

    logic             acc_clr_s, acc_push_s, do_issue_s;
    logic [W-1:0]     acc_s;
    logic             is_digit_s, is_sign_s, is_oper_s, is_minus_s, is_enter_s, is_clr_s;
    logic signed [RES_W-1:0] res_s;

    function automatic logic [W-1:0] apply_sign(input logic neg, input logic [W-1:0] mag);
        return neg ? ({W{1'b0}} - mag) : mag;
    endfunction

    assign is_digit_s = key_valid_i && (key_code_i <= 4'd9);
    assign is_minus_s = (key_code_i == KEY_MINUS);
    assign is_sign_s  = key_valid_i && ((key_code_i == KEY_PLUS) || is_minus_s);
    assign is_oper_s  = is_sign_s || (key_valid_i && (key_code_i == KEY_MULT));
    assign is_enter_s = key_valid_i && (key_code_i == KEY_ENTER);
    assign is_clr_s   = key_valid_i && (key_code_i == KEY_CLR);
    assign res_s      = arith.res_data;

    calc_digit_acc #(.W(W), .MAX_DIGITS(MAX_DIGITS)) u_acc (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (acc_clr_s),
        .push_i  (acc_push_s),
        .digit_i (key_code_i),
        .acc_o   (acc_s)
    );

    // Next-state and output decode; clear overrides everything, including an in-flight result
    always_comb begin
        state_d        = state_q;
        neg1_d         = neg1_q;
        neg2_d         = neg2_q;
        a_mag_d        = a_mag_q;
        op_sel_d       = op_sel_q;
        op_valid_d     = op_valid_q;
        op_a_d         = op_a_q;
        op_b_d         = op_b_q;
        timer_d        = timer_q;
        result_d       = result_q;
        result_valid_d = result_valid_q;
        err_d          = err_q;
        acc_clr_s      = 1'b0;
        acc_push_s     = 1'b0;
        do_issue_s     = 1'b0;

        if (is_clr_s) begin
            state_d        = ST_SIGN1;
            neg1_d         = 1'b0;
            neg2_d         = 1'b0;
            a_mag_d        = {W{1'b0}};
            op_sel_d       = OP_ADD;
            op_valid_d     = 1'b0;
            op_a_d         = {W{1'b0}};
            op_b_d         = {W{1'b0}};
            timer_d        = {TMR_W{1'b0}};
            result_d       = {W{1'b0}};
            result_valid_d = 1'b0;
            err_d          = 1'b0;
            acc_clr_s      = 1'b1;
        end else begin
            case (state_q)
                ST_SIGN1, ST_SHOW: begin
                    if (key_valid_i) begin
                        state_d        = ST_SIGN1;
                        result_valid_d = 1'b0;
                        err_d          = 1'b0;
                        if (is_sign_s) begin
                            neg1_d  = is_minus_s;
                            state_d = ST_DIG1;
                        end else if (is_digit_s) begin
                            neg1_d     = 1'b0;
                            acc_push_s = 1'b1;
                            state_d    = ST_DIG1;
                        end else begin
                            neg1_d = neg1_q;
                        end
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_DIG1: begin
                    if (is_digit_s) begin
                        acc_push_s = 1'b1;
                    end else if (is_enter_s || is_oper_s) begin
                        a_mag_d   = acc_s;
                        acc_clr_s = 1'b1;
                        if (is_enter_s) begin
                            state_d = ST_OP;
                        end else begin
                            op_sel_d = key_to_op(key_code_i);
                            state_d  = ST_SIGN2;
                        end
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_OP: begin
                    if (is_oper_s) begin
                        op_sel_d = key_to_op(key_code_i);
                        state_d  = ST_SIGN2;
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_SIGN2: begin
                    if (is_sign_s) begin
                        neg2_d  = is_minus_s;
                        state_d = ST_DIG2;
                    end else if (is_digit_s) begin
                        neg2_d     = 1'b0;
                        acc_push_s = 1'b1;
                        state_d    = ST_DIG2;
                    end else if (is_enter_s) begin
                        do_issue_s = 1'b1;
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_DIG2: begin
                    if (is_digit_s) begin
                        acc_push_s = 1'b1;
                    end else if (is_enter_s) begin
                        do_issue_s = 1'b1;
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_ISSUE: begin
                    if (arith.op_ack) begin
                        op_valid_d = 1'b0;
                        timer_d    = {TMR_W{1'b0}};
                        state_d    = ST_WAIT;
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_WAIT: begin
                    if (arith.res_valid) begin
                        state_d        = ST_SHOW;
                        result_valid_d = 1'b1;
                        if ((res_s > LIM_P) || (res_s < LIM_N)) begin
                            result_d = {W{1'b0}};
                            err_d    = 1'b1;
                        end else begin
                            result_d = arith.res_data[W-1:0];
                            err_d    = 1'b0;
                        end
                    end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                        state_d        = ST_SHOW;
                        result_d       = {W{1'b0}};
                        err_d          = 1'b1;
                        result_valid_d = 1'b1;
                    end else begin
                        timer_d = timer_q + TMR_W'(1);
                    end
                end
                default: begin
                    state_d = ST_SIGN1;
                end
            endcase

            // Operand B is still in the accumulator when enter is seen
            if (do_issue_s) begin
                state_d    = ST_ISSUE;
                op_valid_d = 1'b1;
                op_a_d     = apply_sign(neg1_q, a_mag_q);
                op_b_d     = apply_sign(neg2_q, acc_s);
                acc_clr_s  = 1'b1;
            end else begin
                op_valid_d = op_valid_d;
            end
        end

        busy_d = (state_d == ST_ISSUE) || (state_d == ST_WAIT);
    end

    // Controller state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_SIGN1;
            neg1_q         <= 1'b0;
            neg2_q         <= 1'b0;
            a_mag_q        <= {W{1'b0}};
            op_sel_q       <= OP_ADD;
            op_valid_q     <= 1'b0;
            op_a_q         <= {W{1'b0}};
            op_b_q         <= {W{1'b0}};
            timer_q        <= {TMR_W{1'b0}};
            result_q       <= {W{1'b0}};
            result_valid_q <= 1'b0;
            err_q          <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            neg1_q         <= neg1_d;
            neg2_q         <= neg2_d;
            a_mag_q        <= a_mag_d;
            op_sel_q       <= op_sel_d;
            op_valid_q     <= op_valid_d;
            op_a_q         <= op_a_d;
            op_b_q         <= op_b_d;
            timer_q        <= timer_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            err_q          <= err_d;
            busy_q         <= busy_d;
        end
    end

    assign arith.op_valid = op_valid_q;
    assign arith.op_a     = op_a_q;
    assign arith.op_b     = op_b_q;
    assign arith.op_sel   = op_sel_q;
    assign result_o       = result_q;
    assign result_valid_o = result_valid_q;
    assign err_o          = err_q;
    assign busy_o         = busy_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Self-checking bench for calc_sequencer: table of key sequences with a
// scoreboard of expected operations/results, plus timeout and clear-in-wait sequences.
module tb_calc_sequencer;
    import calc_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [10:0] result;
    logic        result_valid;
    logic        err;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [10:0] a;
        logic [10:0] b;
        logic [1:0]  sel;
        logic [10:0] result;
        logic        err;
    } exp_t;

    typedef struct {
        logic [39:0] keys;
        int          n;
        int          ack_dly;
        logic [23:0] res;
        exp_t        e;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[9];

    always #5 clk = ~clk;

    calc_sequencer_if #(.W(11)) bus ();

    calc_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .key_valid_i    (key_valid),
        .key_code_i     (key_code),
        .arith          (bus),
        .result_o       (result),
        .result_valid_o (result_valid),
        .err_o          (err),
        .busy_o         (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic press(input logic [3:0] k);
        key_valid = 1'b1;
        key_code  = k;
        tick();
        key_valid = 1'b0;
        key_code  = 4'd0;
    endtask

    // Keys are packed as hex nibbles, first key in the most significant used nibble
    task automatic send_keys(input logic [39:0] keys, input int n, input exp_t e, input bit chk_first);
        exp_q.push_back(e);
        for (int i = 0; i < n; i++) begin
            press(keys[4*(n-1-i) +: 4]);
            if (i == 0 && chk_first) begin
                chk("new entry clears result_valid", 32'(result_valid), 32'd0);
                chk("new entry clears err", 32'(err), 32'd0);
            end
        end
    endtask

    task automatic do_issue(input int ack_dly, output exp_t e);
        int w;
        w = 0;
        while (bus.op_valid !== 1'b1 && w < 4) begin
            tick();
            w++;
        end
        chk("op_valid rise", 32'(bus.op_valid), 32'd1);
        e = exp_q.pop_front();
        chk("op_a", 32'(bus.op_a), 32'(e.a));
        chk("op_b", 32'(bus.op_b), 32'(e.b));
        chk("op_sel", 32'(bus.op_sel), 32'(e.sel));
        chk("busy in ISSUE", 32'(busy), 32'd1);
        for (int d = 0; d < ack_dly; d++) begin
            tick();
            chk("hold op_valid", 32'(bus.op_valid), 32'd1);
            chk("hold op_a", 32'(bus.op_a), 32'(e.a));
            chk("hold op_b", 32'(bus.op_b), 32'(e.b));
        end
        bus.op_ack = 1'b1;
        tick();
        bus.op_ack = 1'b0;
        chk("op_valid drop", 32'(bus.op_valid), 32'd0);
        chk("busy in WAIT", 32'(busy), 32'd1);
    endtask

    task automatic give_result(input int dly, input logic [23:0] r, input exp_t e);
        repeat (dly) tick();
        bus.res_valid = 1'b1;
        bus.res_data  = r;
        tick();
        bus.res_valid = 1'b0;
        bus.res_data  = 24'd0;
        chk("result", 32'(result), 32'(e.result));
        chk("err", 32'(err), 32'(e.err));
        chk("result_valid", 32'(result_valid), 32'd1);
        chk("busy in SHOW", 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        exp_t e;
        // A=plus B=minus C=times E=enter F=unused code
        vecs[0] = '{40'h123A45E,   7, 0, 24'd168,      '{11'd123, 11'd45, 2'd0, 11'd168, 1'b0}};
        vecs[1] = '{40'hB7CB8E,    6, 0, 24'd56,       '{11'(-7), 11'(-8), 2'd2, 11'd56, 1'b0}};
        vecs[2] = '{40'h9999C999E, 9, 1, 24'd998001,   '{11'd999, 11'd999, 2'd2, 11'd0, 1'b1}};
        vecs[3] = '{40'h5EB3E,     5, 5, 24'd2,        '{11'd5, 11'd3, 2'd1, 11'd2, 1'b0}};
        vecs[4] = '{40'hBEAE,      4, 0, 24'd0,        '{11'd0, 11'd0, 2'd0, 11'd0, 1'b0}};
        vecs[5] = '{40'h999CB1E,   7, 2, 24'(-999),    '{11'd999, 11'(-1), 2'd2, 11'(-999), 1'b0}};
        vecs[6] = '{40'h500A500E,  8, 0, 24'd1000,     '{11'd500, 11'd500, 2'd0, 11'd0, 1'b1}};
        vecs[7] = '{40'hB500B500E, 9, 1, 24'(-1000),   '{11'(-500), 11'd500, 2'd1, 11'd0, 1'b1}};
        vecs[8] = '{40'hCF4C2E,    6, 0, 24'd8,        '{11'd4, 11'd2, 2'd2, 11'd8, 1'b0}};

        rst           = 1'b1;
        key_valid     = 1'b0;
        key_code      = 4'd0;
        bus.op_ack    = 1'b0;
        bus.res_valid = 1'b0;
        bus.res_data  = 24'd0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        chk("reset op_valid", 32'(bus.op_valid), 32'd0);
        chk("reset op_a", 32'(bus.op_a), 32'd0);
        chk("reset op_b", 32'(bus.op_b), 32'd0);
        chk("reset op_sel", 32'(bus.op_sel), 32'd0);
        chk("reset result", 32'(result), 32'd0);
        chk("reset result_valid", 32'(result_valid), 32'd0);
        chk("reset err", 32'(err), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);

        for (int i = 0; i < 9; i++) begin
            send_keys(vecs[i].keys, vecs[i].n, vecs[i].e, i > 0);
            do_issue(vecs[i].ack_dly, e);
            give_result(i % 3, vecs[i].res, e);
        end

        // No response: WAIT lasts exactly TIMEOUT cycles, then a late response is ignored
        send_keys(40'h3A4E, 4, '{11'd3, 11'd4, 2'd0, 11'd0, 1'b1}, 1'b1);
        do_issue(0, e);
        repeat (14) tick();
        chk("timeout not yet", 32'(result_valid), 32'd0);
        chk("timeout busy", 32'(busy), 32'd1);
        tick();
        chk("timeout result_valid", 32'(result_valid), 32'd1);
        chk("timeout err", 32'(err), 32'(e.err));
        chk("timeout result", 32'(result), 32'(e.result));
        chk("timeout busy drop", 32'(busy), 32'd0);
        bus.res_valid = 1'b1;
        bus.res_data  = 24'd5;
        tick();
        bus.res_valid = 1'b0;
        bus.res_data  = 24'd0;
        chk("late res ignored result", 32'(result), 32'd0);
        chk("late res ignored err", 32'(err), 32'd1);

        // Clear while waiting discards the in-flight result
        send_keys(40'h6A1E, 4, '{11'd6, 11'd1, 2'd0, 11'd0, 1'b0}, 1'b1);
        do_issue(0, e);
        press(KEY_CLR);
        bus.res_valid = 1'b1;
        bus.res_data  = 24'd7;
        tick();
        bus.res_valid = 1'b0;
        bus.res_data  = 24'd0;
        chk("clear result", 32'(result), 32'd0);
        chk("clear result_valid", 32'(result_valid), 32'd0);
        chk("clear err", 32'(err), 32'd0);
        chk("clear busy", 32'(busy), 32'd0);
        chk("clear op_a", 32'(bus.op_a), 32'd0);
        chk("clear op_sel", 32'(bus.op_sel), 32'd0);
        send_keys(40'h2B3E, 4, '{11'd2, 11'd3, 2'd1, 11'(-1), 1'b0}, 1'b0);
        do_issue(0, e);
        give_result(1, 24'hFFFFFF, e);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/calc_sequencer.md
Name: calc_sequencer

Overview:
Key-driven controller for the calculator arithmetic datapath (add/sub/booth multiply unit). Consumes decoded key events (0-14), assembles two signed decimal operands and an operator, issues one operation to the shared arithmetic unit over a valid/ack handshake, and waits for the result. It then range-checks the result and presents it to the display path with an error flag. Sits between the keypad scan-code decoder and the arithmetic unit/display driver.

Parameters:
W, 11, operand/result width (two's complement)
MAX_DIGITS, 3, decimal digits accepted per operand
LIMIT, 999, magnitude limit for a valid result
TIMEOUT, 15, cycles to wait for res_valid before flagging error

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
key_valid  in  1  one-cycle strobe, key_code valid
key_code  in  4  0-9 digit, 10 plus, 11 minus, 12 times, 13 clear, 14 enter
op_valid  out  1  operation request to arithmetic unit
op_ack  in  1  arithmetic unit accepted request
op_a  out  W  signed operand A
op_b  out  W  signed operand B
op_sel  out  2  0 add, 1 sub, 2 mult
res_valid  in  1  one-cycle strobe, res_data valid
res_data  in  24  signed result from arithmetic unit
result  out  W  signed value for display
result_valid  out  1  high while result holds a completed operation
err  out  1  overflow/timeout/illegal flag
busy  out  1  high in ISSUE and WAIT

Behaviour:
- Reset: state SIGN1; all outputs 0; operands, signs, digit count, operator 0.
- Keys are acted on only in cycles with key_valid=1. Codes 15 and 12 in non-operator states are ignored.
- Clear (13) in any state: next cycle state SIGN1, all internal regs and outputs 0, op_valid dropped (an in-flight result is discarded).
- SIGN1: 10 -> neg1=0, DIG1; 11 -> neg1=1, DIG1; digit d -> acc1=d, cnt=1, DIG1.
- DIG1: digit -> acc1=acc1*10+d, cnt+1, while cnt<MAX_DIGITS; extra digits ignored. 14/10/11/12 -> OP; 10/11/12 also latch the operator immediately and go to SIGN2.
- OP: 10/11/12 latch op_sel 0/1/2 -> SIGN2; other keys ignored.
- SIGN2/DIG2: mirror SIGN1/DIG1 for operand B; 14 in DIG2 -> ISSUE. 14 in SIGN2 -> ISSUE with B=0.
- Enter with zero digits entered -> that operand is 0; sign is still applied (-0 = 0).
- ISSUE: op_a = neg1 ? -acc1 : acc1, op_b likewise, both driven on entry; op_valid=1 and op_a/op_b/op_sel held stable until the cycle op_ack=1; next cycle op_valid=0, state WAIT, timer cleared.
- WAIT: res_valid -> SHOW; if res_data > LIMIT or < -LIMIT then result=0, err=1; else result=res_data[W-1:0], err=0; result_valid=1. Timer reaching TIMEOUT without res_valid -> result=0, err=1, result_valid=1, SHOW. Keys other than clear are ignored in ISSUE/WAIT.
- Latency: result updates the cycle after res_valid is seen.
- SHOW: outputs held. Any key except 13 starts a new entry, processed exactly as in SIGN1 (result_valid and err cleared the same cycle).
- res_valid outside WAIT is ignored; op_ack outside ISSUE is ignored.
- Accumulator max 999 fits W=11; negation in two's complement W bits.

Decomposition:
- calc_pkg: key code constants (KEY_PLUS=10, KEY_MINUS=11, KEY_MULT=12, KEY_CLR=13, KEY_ENTER=14), op_sel encoding, state enum (SIGN1, DIG1, OP, SIGN2, DIG2, ISSUE, WAIT, SHOW).
- Sub-module calc_digit_acc: decimal accumulator (clear, load digit, acc*10+d, count, saturation at MAX_DIGITS); one instance, reused for A then B, with A captured on leaving DIG1.

Test Plan:
- Keys 1,2,3,+,4,5,enter; ack next cycle; res_data=168 -> op_a=123, op_b=45, op_sel=0, result=168, err=0, result_valid=1.
- Keys -,7,x,-,8,enter; res_data=56 -> op_a=-7, op_b=-8, op_sel=2, result=56.
- Keys 9,9,9,9,x,9,9,9,enter; res_data=998001 -> op_a=999 (4th digit ignored), result=0, err=1.
- op_ack held low 5 cycles in ISSUE -> op_valid, op_a, op_b stable all 5 cycles; drops the cycle after ack.
- No res_valid for TIMEOUT=15 cycles in WAIT -> result=0, err=1, state SHOW; later res_valid ignored.
- Clear pressed in WAIT, then res_valid arrives -> outputs stay 0, state SIGN1; new entry 2,-,3,enter gives op_sel=1, result=-1.
